// File: rtl/if_id_stage_pkg.sv
// Shared definitions for the fetch stage and IF/ID pipeline register.
package if_id_stage_pkg;

  // Instruction word loaded into IF/ID for a bubble or flush.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Default byte distance between sequential instructions.
  localparam int DEFAULT_PC_STEP = 4;

  // Fetch controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,  // no request issued yet
    WAIT = 2'd1,  // live request outstanding
    HOLD = 2'd2,  // fetched word parked while decode is stalled
    DROP = 2'd3   // stale request outstanding after a redirect
  } fetch_state_e;

endpackage

// File: rtl/if_id_stage_reg.sv
// Generic IF/ID style pipeline register: load, flush to NOP, otherwise hold.
module if_id_reg
  import if_id_stage_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_flush,
  input  logic [31:0]       i_instr,
  input  logic [ADDR_W-1:0] i_pc4,
  output logic [31:0]       o_instr,
  output logic [ADDR_W-1:0] o_pc4,
  output logic              o_valid
);

  logic [31:0]       r_instr;
  logic [ADDR_W-1:0] r_pc4;
  logic              r_valid;

  // Flush beats load; the address field is kept on a flush so a bubble
  // does not disturb the last delivered PC+step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr <= NOP_INSTR;
      r_pc4   <= {ADDR_W{1'b0}};
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_instr <= i_instr;
      r_pc4   <= i_pc4;
      r_valid <= 1'b1;
    end else begin
      r_instr <= r_instr;
      r_pc4   <= r_pc4;
      r_valid <= r_valid;
    end
  end

  assign o_instr = r_instr;
  assign o_pc4   = r_pc4;
  assign o_valid = r_valid;

endmodule

// File: rtl/if_id_stage.sv
// Fetch stage: program counter, request/ack instruction-memory port and the
// IF/ID register feeding decode. Branch redirect outranks stall and ack.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
  parameter int              PC_STEP  = DEFAULT_PC_STEP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stop,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instruction_id,
  output logic [ADDR_W-1:0] pc_plus4_id,
  output logic              valid_id
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  fetch_state_e      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_req_addr;
  logic              r_imem_req;
  logic [31:0]       r_hold_instr;
  logic [ADDR_W-1:0] r_hold_pc4;
  logic              r_hold_valid;

  fetch_state_e      w_next_state;
  logic [ADDR_W-1:0] w_next_pc;
  logic [ADDR_W-1:0] w_next_req_addr;
  logic [ADDR_W-1:0] w_seq_addr;
  logic              w_id_load;
  logic              w_id_flush;
  logic              w_id_src_hold;
  logic              w_hold_cap;
  logic              w_hold_clr;
  logic [31:0]       w_load_instr;
  logic [ADDR_W-1:0] w_load_pc4;

  // Wraps modulo 2^ADDR_W by construction of the vector width.
  assign w_seq_addr = r_req_addr + STEP;

  // Next-state, PC and IF/ID control decode.
  always_comb begin
    w_next_state    = r_state;
    w_next_pc       = r_pc;
    w_next_req_addr = r_req_addr;
    w_id_load       = 1'b0;
    w_id_flush      = 1'b0;
    w_id_src_hold   = 1'b0;
    w_hold_cap      = 1'b0;
    w_hold_clr      = 1'b0;
    case (r_state)
      IDLE: begin
        w_next_state = WAIT;
        if (branch_taken) begin
          w_next_pc       = branch_target;
          w_next_req_addr = branch_target;
          w_id_flush      = 1'b1;
          w_hold_clr      = 1'b1;
        end else begin
          w_next_req_addr = r_pc;
        end
      end
      WAIT: begin
        if (branch_taken) begin
          w_next_pc  = branch_target;
          w_id_flush = 1'b1;
          w_hold_clr = 1'b1;
          if (imem_ack) begin
            w_next_req_addr = branch_target;
          end else begin
            w_next_state = DROP;
          end
        end else if (imem_ack) begin
          if (!stop) begin
            w_id_load       = 1'b1;
            w_next_pc       = w_seq_addr;
            w_next_req_addr = w_seq_addr;
          end else begin
            w_hold_cap   = 1'b1;
            w_next_state = HOLD;
          end
        end else if (!stop) begin
          w_id_flush = 1'b1;
        end else begin
          w_next_state = WAIT;
        end
      end
      HOLD: begin
        if (branch_taken) begin
          w_next_pc       = branch_target;
          w_next_req_addr = branch_target;
          w_id_flush      = 1'b1;
          w_hold_clr      = 1'b1;
          w_next_state    = WAIT;
        end else if (!stop && r_hold_valid) begin
          w_id_load       = 1'b1;
          w_id_src_hold   = 1'b1;
          w_next_pc       = r_hold_pc4;
          w_next_req_addr = r_hold_pc4;
          w_hold_clr      = 1'b1;
          w_next_state    = WAIT;
        end else begin
          w_next_state = HOLD;
        end
      end
      DROP: begin
        // A redirect landing on the stale ack itself re-issues at once;
        // otherwise waiting for a second ack would never end.
        if (branch_taken) begin
          w_next_pc  = branch_target;
          w_id_flush = 1'b1;
          w_hold_clr = 1'b1;
          if (imem_ack) begin
            w_next_req_addr = branch_target;
            w_next_state    = WAIT;
          end else begin
            w_next_state = DROP;
          end
        end else if (imem_ack) begin
          w_next_req_addr = r_pc;
          w_next_state    = WAIT;
        end else begin
          w_next_state = DROP;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Source of the word written into IF/ID: memory or the parked word.
  always_comb begin
    w_load_instr = imem_rdata;
    w_load_pc4   = w_seq_addr;
    if (w_id_src_hold) begin
      w_load_instr = r_hold_instr;
      w_load_pc4   = r_hold_pc4;
    end else begin
      w_load_instr = imem_rdata;
      w_load_pc4   = w_seq_addr;
    end
  end

  // Fetch state, PC, request address and registered request strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_imem_req <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_pc       <= w_next_pc;
      r_req_addr <= w_next_req_addr;
      r_imem_req <= (w_next_state == WAIT) || (w_next_state == DROP);
    end
  end

  // Hold buffer: parks a word acknowledged while decode was stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold_instr <= NOP_INSTR;
      r_hold_pc4   <= {ADDR_W{1'b0}};
      r_hold_valid <= 1'b0;
    end else if (w_hold_clr) begin
      r_hold_instr <= NOP_INSTR;
      r_hold_pc4   <= {ADDR_W{1'b0}};
      r_hold_valid <= 1'b0;
    end else if (w_hold_cap) begin
      r_hold_instr <= imem_rdata;
      r_hold_pc4   <= w_seq_addr;
      r_hold_valid <= 1'b1;
    end else begin
      r_hold_instr <= r_hold_instr;
      r_hold_pc4   <= r_hold_pc4;
      r_hold_valid <= r_hold_valid;
    end
  end

  if_id_reg #(.ADDR_W(ADDR_W)) u_if_id_reg (
    .clk     (clk),
    .rst_n   (rst),
    .i_load  (w_id_load),
    .i_flush (w_id_flush),
    .i_instr (w_load_instr),
    .i_pc4   (w_load_pc4),
    .o_instr (instruction_id),
    .o_pc4   (pc_plus4_id),
    .o_valid (valid_id)
  );

  assign imem_req  = r_imem_req;
  assign imem_addr = r_req_addr;

endmodule

// File: tb/tb_if_id_stage.sv
// Randomized bench for if_id_stage with a transaction-level reference model.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stop, branch_taken, imem_ack;
  logic [31:0] branch_target, imem_rdata;
  logic        imem_req, valid_id;
  logic [31:0] imem_addr, instruction_id, pc_plus4_id;

  logic        ack2, req2, valid2;
  logic [31:0] rdata2, addr2, instr2, pc4_2;
  logic        stop2, br2;
  logic [31:0] tgt2;

  int total = 0;
  int bad   = 0;

  // Reference model state (outstanding request / stale flag / parked word).
  logic        m_req, m_stale, m_held, m_valid;
  logic [31:0] m_pc, m_addr, m_held_word, m_held_next, m_instr, m_pc4;
  logic        salt_mode;

  if_id_stage dut (
    .clk(clk), .rst(rst), .stop(stop), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instruction_id(instruction_id),
    .pc_plus4_id(pc_plus4_id), .valid_id(valid_id)
  );

  if_id_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .stop(stop2), .branch_taken(br2),
    .branch_target(tgt2), .imem_req(req2), .imem_addr(addr2),
    .imem_ack(ack2), .imem_rdata(rdata2), .instruction_id(instr2),
    .pc_plus4_id(pc4_2), .valid_id(valid2)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_req = 1'b0; m_stale = 1'b0; m_held = 1'b0;
    m_pc = 32'h0; m_addr = 32'h0;
    m_held_word = 32'h0; m_held_next = 32'h0;
    m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
  endfunction

  // One clock of fetch behaviour expressed as transaction rules.
  function automatic void model_step(input logic br, input logic [31:0] tgt,
                                     input logic st, input logic ak, input logic [31:0] rd);
    logic [31:0] nxt;
    nxt = m_addr + 32'd4;
    if (br) begin
      m_instr = 32'h0; m_valid = 1'b0; m_held = 1'b0; m_pc = tgt;
      if (m_req && !ak) begin
        m_stale = 1'b1;
      end else begin
        m_req = 1'b1; m_stale = 1'b0; m_addr = tgt;
      end
    end else if (!m_req && !m_held) begin
      m_req = 1'b1; m_addr = m_pc;
    end else if (m_held) begin
      if (!st) begin
        m_instr = m_held_word; m_pc4 = m_held_next; m_valid = 1'b1;
        m_pc = m_held_next; m_addr = m_held_next; m_held = 1'b0; m_req = 1'b1;
      end
    end else if (m_stale) begin
      if (ak) begin
        m_stale = 1'b0; m_addr = m_pc;
      end
    end else if (ak) begin
      if (!st) begin
        m_instr = rd; m_pc4 = nxt; m_valid = 1'b1; m_pc = nxt; m_addr = nxt;
      end else begin
        m_held = 1'b1; m_held_word = rd; m_held_next = nxt; m_req = 1'b0;
      end
    end else if (!st) begin
      m_instr = 32'h0; m_valid = 1'b0;
    end
  endfunction

  task automatic compare_all(input string tag);
    check_eq({tag, ".req"},   {31'd0, imem_req}, {31'd0, m_req});
    check_eq({tag, ".addr"},  imem_addr, m_addr);
    check_eq({tag, ".instr"}, instruction_id, m_instr);
    check_eq({tag, ".pc4"},   pc_plus4_id, m_pc4);
    check_eq({tag, ".valid"}, {31'd0, valid_id}, {31'd0, m_valid});
  endtask

  // Drive one cycle from the falling edge, advance the model, check next fall.
  task automatic cycle(input string tag, input logic br, input logic [31:0] tgt,
                       input logic st, input logic ak);
    logic        a;
    logic [31:0] rd;
    a  = ak && m_req;
    rd = salt_mode ? $urandom : m_addr;
    branch_taken = br; branch_target = tgt; stop = st; imem_ack = a; imem_rdata = rd;
    @(posedge clk);
    model_step(br, tgt, st, a, rd);
    @(negedge clk);
    imem_ack = 1'b0;
    compare_all(tag);
  endtask

  initial begin
    logic [31:0] rt;
    rst = 1'b0; stop = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0; salt_mode = 1'b0;
    ack2 = 1'b0; rdata2 = 32'h0; stop2 = 1'b0; br2 = 1'b0; tgt2 = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all("reset");
    rst = 1'b1;

    // Sequential fetch, word = address.
    cycle("start", 1'b0, 32'h0, 1'b0, 1'b1);
    check_eq("first_addr", imem_addr, 32'h0);
    cycle("seq0", 1'b0, 32'h0, 1'b0, 1'b1);
    check_eq("seq0_instr", instruction_id, 32'h0);
    check_eq("seq0_pc4", pc_plus4_id, 32'h4);
    cycle("seq1", 1'b0, 32'h0, 1'b0, 1'b1);
    check_eq("seq1_instr", instruction_id, 32'h4);
    check_eq("seq1_addr", imem_addr, 32'h8);

    // Ack at 8 while stalled, stall held three cycles.
    cycle("hold0", 1'b0, 32'h0, 1'b1, 1'b1);
    check_eq("hold_req", {31'd0, imem_req}, 32'd0);
    check_eq("hold_keep", instruction_id, 32'h4);
    cycle("hold1", 1'b0, 32'h0, 1'b1, 1'b0);
    cycle("hold2", 1'b0, 32'h0, 1'b1, 1'b0);
    cycle("release", 1'b0, 32'h0, 1'b0, 1'b0);
    check_eq("rel_instr", instruction_id, 32'h8);
    check_eq("rel_pc4", pc_plus4_id, 32'hC);
    check_eq("rel_addr", imem_addr, 32'hC);

    // Redirect with no ack: stale request to 12 must finish first.
    cycle("br_drop", 1'b1, 32'h100, 1'b0, 1'b0);
    check_eq("drop_addr", imem_addr, 32'hC);
    check_eq("drop_valid", {31'd0, valid_id}, 32'd0);
    cycle("drop_wait", 1'b0, 32'h0, 1'b0, 1'b0);
    cycle("drop_ack", 1'b0, 32'h0, 1'b0, 1'b1);
    check_eq("drop_discard", {31'd0, valid_id}, 32'd0);
    check_eq("drop_next", imem_addr, 32'h100);

    // Branch, stop and ack together.
    cycle("all3", 1'b1, 32'h100, 1'b1, 1'b1);
    check_eq("all3_valid", {31'd0, valid_id}, 32'd0);
    check_eq("all3_addr", imem_addr, 32'h100);
    cycle("all3_after", 1'b0, 32'h0, 1'b0, 1'b1);

    // Reset while a stale request is outstanding.
    cycle("pre_rst", 1'b1, 32'h300, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    model_reset();
    compare_all("rst_async");
    check_eq("rst_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    cycle("rst_restart", 1'b0, 32'h0, 1'b0, 1'b0);
    check_eq("rst_first_addr", imem_addr, 32'h0);

    // Randomized traffic.
    salt_mode = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      rt = $urandom;
      rt[1:0] = 2'b00;
      cycle("rand", ($urandom_range(0, 7) == 0), rt,
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1));
    end

    // Address wrap on the second instance.
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    cycle("wrap_start", 1'b0, 32'h0, 1'b0, 1'b0);
    check_eq("wrap_addr0", addr2, 32'hFFFF_FFFC);
    check_eq("wrap_req0", {31'd0, req2}, 32'd1);
    ack2 = 1'b1; rdata2 = 32'h1234_5678;
    cycle("wrap_ack", 1'b0, 32'h0, 1'b0, 1'b0);
    ack2 = 1'b0;
    check_eq("wrap_instr", instr2, 32'h1234_5678);
    check_eq("wrap_pc4", pc4_2, 32'h0);
    check_eq("wrap_next", addr2, 32'h0);
    check_eq("wrap_valid", {31'd0, valid2}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
